// File: rtl/qblock_pkg.sv
// Shared types and constants for the question-block animation controller.
package qblock_pkg;

  typedef enum logic [1:0] {
    BLINK     = 2'd0,
    BUMP_UP   = 2'd1,
    BUMP_DOWN = 2'd2,
    USED      = 2'd3
  } qblock_state_t;

  localparam int unsigned SPRITE_W      = 20;
  localparam int unsigned SPRITE_H      = 20;
  localparam int unsigned SPRITE_PIXELS = 400;
  localparam int unsigned ADDR_W        = $clog2(SPRITE_PIXELS);

  localparam logic [1:0] FRAME_USED = 2'd3;

  // Blink sequence 0,1,2,1 packed with entry 0 in the low bits.
  localparam logic [7:0] BLINK_SEQ = {2'd1, 2'd2, 2'd1, 2'd0};

  // Sprite frame shown at a given blink sequence index.
  function automatic logic [1:0] blink_frame(input logic [1:0] idx);
    return BLINK_SEQ[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/frame_tick_det.sv
// Rising-edge detector turning the frame_clk level into a one-cycle tick.
module frame_tick_det (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick_c
);

  logic frame_clk_q;

  // Previous frame_clk level; cleared by reset so a rise is seen fresh.
  always_ff @(posedge Clk) begin
    if (Reset) frame_clk_q <= 1'b0;
    else       frame_clk_q <= frame_clk;
  end

  assign tick_c = frame_clk & ~frame_clk_q;

endmodule

// File: rtl/qblock_anim_ctrl.sv
// Question-block animation controller: blink cycle, hit bump, spent state,
// and sprite ROM address generation.
// Optional feature macro: QBLOCK_BUMP_EN (bump animation on hit).
module qblock_anim_ctrl
  import qblock_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 8,
  parameter int unsigned BUMP_HEIGHT = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              hit,
  input  logic              in_block,
  input  logic [4:0]        pix_x,
  input  logic [4:0]        pix_y,
  output logic [ADDR_W-1:0] read_address,
  output logic              addr_valid,
  output logic [1:0]        frame_sel,
  output logic [3:0]        bump_dy,
  output logic              used,
  output logic              busy
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  // Reject parameter values the counters cannot represent.
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255 || BUMP_HEIGHT < 1 || BUMP_HEIGHT > 15) begin : g_param_check
    $error("qblock_anim_ctrl: HOLD_FRAMES or BUMP_HEIGHT out of range");
  end

  logic tick_c;

  frame_tick_det u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick_c    (tick_c)
  );

  // Address path: row-major index into the 20x20 sprite.
  logic              in_range_c;
  logic [ADDR_W-1:0] addr_c;

  assign in_range_c = in_block && (pix_x < 5'(SPRITE_W)) && (pix_y < 5'(SPRITE_H));
  assign addr_c     = ADDR_W'(pix_y) * ADDR_W'(SPRITE_W) + ADDR_W'(pix_x);

  // Registered sprite address with validity flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      addr_valid   <= 1'b0;
    end else if (in_range_c) begin
      read_address <= addr_c;
      addr_valid   <= 1'b1;
    end else begin
      read_address <= '0;
      addr_valid   <= 1'b0;
    end
  end

  qblock_state_t state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    frame_sel_q, frame_sel_d;
  logic          used_q, used_d;

`ifdef QBLOCK_BUMP_EN
  localparam logic [3:0] BUMP_LAST = 4'(BUMP_HEIGHT - 1);

  logic [3:0] dy_q, dy_d;
  logic       busy_q, busy_d;

  // Bump offset and busy registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dy_q   <= 4'd0;
      busy_q <= 1'b0;
    end else begin
      dy_q   <= dy_d;
      busy_q <= busy_d;
    end
  end

  assign bump_dy = dy_q;
  assign busy    = busy_q;
`else
  assign bump_dy = 4'd0;
  assign busy    = 1'b0;
`endif

  // State, blink counters and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= BLINK;
      hold_q      <= 8'd0;
      idx_q       <= 2'd0;
      frame_sel_q <= 2'd0;
      used_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      frame_sel_q <= frame_sel_d;
      used_q      <= used_d;
    end
  end

  // Next-state and next-output logic; a hit in BLINK beats a coincident tick.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    frame_sel_d = frame_sel_q;
    used_d      = used_q;
`ifdef QBLOCK_BUMP_EN
    dy_d        = dy_q;
    busy_d      = busy_q;
`endif

    case (state_q)
      BLINK: begin
        if (hit) begin
          frame_sel_d = FRAME_USED;
`ifdef QBLOCK_BUMP_EN
          state_d     = BUMP_UP;
          dy_d        = 4'd0;
          busy_d      = 1'b1;
`else
          state_d     = USED;
          used_d      = 1'b1;
`endif
        end else if (tick_c) begin
          if (hold_q >= HOLD_LAST) begin
            hold_d = 8'd0;
            idx_d  = idx_q + 2'd1;
          end else begin
            hold_d = hold_q + 8'd1;
          end
          frame_sel_d = blink_frame(idx_d);
        end
      end
`ifdef QBLOCK_BUMP_EN
      BUMP_UP: begin
        if (tick_c) begin
          if (dy_q >= BUMP_LAST) begin
            dy_d    = 4'(BUMP_HEIGHT);
            state_d = BUMP_DOWN;
          end else begin
            dy_d    = dy_q + 4'd1;
          end
        end
      end
      BUMP_DOWN: begin
        if (tick_c) begin
          if (dy_q <= 4'd1) begin
            dy_d    = 4'd0;
            busy_d  = 1'b0;
            used_d  = 1'b1;
            state_d = USED;
          end else begin
            dy_d    = dy_q - 4'd1;
          end
        end
      end
`endif
      USED: begin
        frame_sel_d = FRAME_USED;
        used_d      = 1'b1;
      end
      default: begin
        state_d = BLINK;
      end
    endcase
  end

  assign frame_sel = frame_sel_q;
  assign used      = used_q;

endmodule

// File: tb/tb_qblock_anim_ctrl.sv
// Directed self-checking bench for qblock_anim_ctrl (HOLD_FRAMES=2, BUMP_HEIGHT=8).
module tb_qblock_anim_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       hit;
  logic       in_block;
  logic [4:0] pix_x;
  logic [4:0] pix_y;
  logic [8:0] read_address;
  logic       addr_valid;
  logic [1:0] frame_sel;
  logic [3:0] bump_dy;
  logic       used;
  logic       busy;

  int passed = 0;
  int total  = 0;

  qblock_anim_ctrl #(
    .HOLD_FRAMES (2),
    .BUMP_HEIGHT (8)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .hit          (hit),
    .in_block     (in_block),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .read_address (read_address),
    .addr_valid   (addr_valid),
    .frame_sel    (frame_sel),
    .bump_dy      (bump_dy),
    .used         (used),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (read_address !== 9'd0) $display("FAIL reset_addr got=%0d exp=0", read_address); else passed++;
    total++; if (addr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", addr_valid); else passed++;
    total++; if (frame_sel !== 2'd0) $display("FAIL reset_frame_sel got=%0d exp=0", frame_sel); else passed++;
    total++; if (bump_dy !== 4'd0) $display("FAIL reset_bump_dy got=%0d exp=0", bump_dy); else passed++;
    total++; if (used !== 1'b0) $display("FAIL reset_used got=%b exp=0", used); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_blink();
    logic [1:0] exp_seq [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    do_reset();
    total++; if (frame_sel !== exp_seq[0]) $display("FAIL blink_0 got=%0d exp=%0d", frame_sel, exp_seq[0]); else passed++;
    for (int i = 1; i < 9; i++) begin
      tick();
      total++;
      if (frame_sel !== exp_seq[i]) $display("FAIL blink_%0d got=%0d exp=%0d", i, frame_sel, exp_seq[i]);
      else passed++;
    end
    // A long high level is a single tick: first hold step only.
    frame_clk = 1'b1;
    repeat (4) step();
    frame_clk = 1'b0;
    step();
    total++; if (frame_sel !== 2'd0) $display("FAIL level_hold got=%0d exp=0", frame_sel); else passed++;
    tick();
    total++; if (frame_sel !== 2'd1) $display("FAIL level_next got=%0d exp=1", frame_sel); else passed++;
  endtask

  task automatic test_address();
    logic [4:0] vx [5] = '{5'd19, 5'd20, 5'd0, 5'd3, 5'd0};
    logic [4:0] vy [5] = '{5'd19, 5'd19, 5'd0, 5'd2, 5'd20};
    logic       vb [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [8:0] ea [5] = '{9'd399, 9'd0, 9'd0, 9'd43, 9'd0};
    logic       ev [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pix_x = vx[i]; pix_y = vy[i]; in_block = vb[i];
      if (i == 0) begin
        #2;
        total++; if (addr_valid !== 1'b0) $display("FAIL addr_latency got=%b exp=0", addr_valid); else passed++;
      end
      step();
      total++;
      if (read_address !== ea[i]) $display("FAIL addr_%0d got=%0d exp=%0d", i, read_address, ea[i]); else passed++;
      total++;
      if (addr_valid !== ev[i]) $display("FAIL valid_%0d got=%b exp=%b", i, addr_valid, ev[i]); else passed++;
    end
    in_block = 1'b0; pix_x = 5'd0; pix_y = 5'd0;
  endtask

`ifdef QBLOCK_BUMP_EN
  task automatic test_bump();
    do_reset();
    pulse_hit();
    step();
    total++; if (busy !== 1'b1 || bump_dy !== 4'd0 || frame_sel !== 2'd3 || used !== 1'b0)
      $display("FAIL bump_start got busy=%b dy=%0d fs=%0d used=%b exp 1/0/3/0", busy, bump_dy, frame_sel, used); else passed++;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++; if (bump_dy !== 4'(i)) $display("FAIL bump_up_%0d got=%0d exp=%0d", i, bump_dy, i); else passed++;
      if (i == 4) begin
        pulse_hit();
        step();
        total++; if (bump_dy !== 4'd4 || busy !== 1'b1 || frame_sel !== 2'd3)
          $display("FAIL bump_rehit got dy=%0d busy=%b fs=%0d exp 4/1/3", bump_dy, busy, frame_sel); else passed++;
      end
    end
    for (int i = 7; i >= 0; i--) begin
      tick();
      total++; if (bump_dy !== 4'(i)) $display("FAIL bump_down_%0d got=%0d exp=%0d", i, bump_dy, i); else passed++;
    end
    total++; if (used !== 1'b1 || busy !== 1'b0 || frame_sel !== 2'd3)
      $display("FAIL bump_done got used=%b busy=%b fs=%0d exp 1/0/3", used, busy, frame_sel); else passed++;
    pulse_hit();
    tick(); tick();
    total++; if (used !== 1'b1 || busy !== 1'b0 || bump_dy !== 4'd0 || frame_sel !== 2'd3)
      $display("FAIL used_terminal got used=%b busy=%b dy=%0d fs=%0d exp 1/0/0/3", used, busy, bump_dy, frame_sel); else passed++;
  endtask

  task automatic test_hit_tick();
    do_reset();
    tick();
    frame_clk = 1'b1; hit = 1'b1;
    step();
    frame_clk = 1'b0; hit = 1'b0;
    step();
    total++; if (busy !== 1'b1 || bump_dy !== 4'd0 || frame_sel !== 2'd3)
      $display("FAIL hit_tick got busy=%b dy=%0d fs=%0d exp 1/0/3", busy, bump_dy, frame_sel); else passed++;
    total++; if (dut.idx_q !== 2'd0 || dut.hold_q !== 8'd1)
      $display("FAIL hit_tick_blink got idx=%0d hold=%0d exp 0/1", dut.idx_q, dut.hold_q); else passed++;
  endtask

  task automatic test_reset_mid_bump();
    do_reset();
    pulse_hit();
    repeat (11) tick();
    total++; if (bump_dy !== 4'd5) $display("FAIL mid_bump_dy got=%0d exp=5", bump_dy); else passed++;
    Reset = 1'b1; hit = 1'b1; frame_clk = 1'b1;
    step();
    Reset = 1'b0; hit = 1'b0; frame_clk = 1'b0;
    total++; if (bump_dy !== 4'd0 || busy !== 1'b0 || used !== 1'b0 || frame_sel !== 2'd0 || addr_valid !== 1'b0)
      $display("FAIL abort_reset got dy=%0d busy=%b used=%b fs=%0d valid=%b exp all 0", bump_dy, busy, used, frame_sel, addr_valid); else passed++;
    step();
    total++; if (busy !== 1'b0) $display("FAIL abort_no_hit got=%b exp=0", busy); else passed++;
    tick(); tick();
    total++; if (frame_sel !== 2'd1) $display("FAIL abort_blink got=%0d exp=1", frame_sel); else passed++;
  endtask
`else
  task automatic test_hit_used();
    do_reset();
    pulse_hit();
    total++; if (used !== 1'b1 || frame_sel !== 2'd3 || busy !== 1'b0 || bump_dy !== 4'd0)
      $display("FAIL hit_used got used=%b fs=%0d busy=%b dy=%0d exp 1/3/0/0", used, frame_sel, busy, bump_dy); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (busy !== 1'b0 || used !== 1'b1 || frame_sel !== 2'd3)
        $display("FAIL used_stay_%0d got busy=%b used=%b fs=%0d exp 0/1/3", i, busy, used, frame_sel); else passed++;
    end
  endtask

  task automatic test_hit_tick();
    do_reset();
    tick();
    frame_clk = 1'b1; hit = 1'b1;
    step();
    frame_clk = 1'b0; hit = 1'b0;
    total++; if (used !== 1'b1 || frame_sel !== 2'd3 || busy !== 1'b0)
      $display("FAIL hit_tick got used=%b fs=%0d busy=%b exp 1/3/0", used, frame_sel, busy); else passed++;
    total++; if (dut.idx_q !== 2'd0 || dut.hold_q !== 8'd1)
      $display("FAIL hit_tick_blink got idx=%0d hold=%0d exp 0/1", dut.idx_q, dut.hold_q); else passed++;
  endtask
`endif

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; hit = 1'b0;
    in_block = 1'b0; pix_x = 5'd0; pix_y = 5'd0;
    test_reset();
    test_blink();
    test_address();
`ifdef QBLOCK_BUMP_EN
    test_bump();
    test_hit_tick();
    test_reset_mid_bump();
`else
    test_hit_used();
    test_hit_tick();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
